// File: rtl/idu_queue.sv
// Instruction decode stage: decodes one RV instruction per cycle and buffers
// the decoded bundles in a DEPTH-entry FIFO between fetch and execute.
module idu_queue #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [7:0]      out_cls,
  output logic            out_wb,
  output logic            out_w,
  output logic            out_call,
  output logic            out_ret,
  output logic            out_illegal
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_IMM    = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_IMM32  = 7'h1B;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_OP32   = 7'h3B;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [XLEN-1:0] imm;
    logic [7:0]      cls;
    logic            wb;
    logic            w;
    logic            call;
    logic            ret;
    logic            illegal;
  } entry_t;

  entry_t      dec;
  logic [6:0]  opc;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [2:0]  f3;
  logic [63:0] imm64;
  logic [7:0]  cls_raw;
  logic        supported;
  logic        is_w;
  logic        illegal;
  logic        wb_fmt;
  logic        call_raw;
  logic        ret_raw;
  logic        rd_link;
  logic        rs1_link;

  // Combinational decode of the incoming instruction word
  always_comb begin
    opc       = in_inst[6:0];
    rd        = in_inst[11:7];
    rs1       = in_inst[19:15];
    f3        = in_inst[14:12];
    imm64     = '0;
    cls_raw   = '0;
    supported = 1'b1;
    wb_fmt    = 1'b0;
    call_raw  = 1'b0;
    ret_raw   = 1'b0;
    rd_link   = (rd == 5'd1) || (rd == 5'd5);
    rs1_link  = (rs1 == 5'd1) || (rs1 == 5'd5);
    is_w      = (opc == OPC_OP32) || (opc == OPC_IMM32);

    case (opc)
      OPC_IMM, OPC_IMM32, OPC_LOAD: begin
        imm64   = {{52{in_inst[31]}}, in_inst[31:20]};
        cls_raw = (opc == OPC_LOAD) ? 8'h08 : 8'h01;
        wb_fmt  = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm64   = {{32{in_inst[31]}}, in_inst[31:12], 12'h000};
        cls_raw = 8'h01;
        wb_fmt  = 1'b1;
      end
      OPC_OP, OPC_OP32: begin
        cls_raw = !in_inst[25] ? 8'h01 : (in_inst[14] ? 8'h04 : 8'h02);
        wb_fmt  = 1'b1;
      end
      OPC_STORE: begin
        imm64   = {{52{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        cls_raw = 8'h10;
      end
      OPC_BRANCH: begin
        imm64   = {{51{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                   in_inst[11:8], 1'b0};
        cls_raw = 8'h20;
      end
      OPC_JAL: begin
        imm64    = {{43{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                    in_inst[30:21], 1'b0};
        cls_raw  = 8'h40;
        wb_fmt   = 1'b1;
        call_raw = rd_link;
      end
      OPC_JALR: begin
        imm64    = {{52{in_inst[31]}}, in_inst[31:20]};
        cls_raw  = 8'h40;
        wb_fmt   = 1'b1;
        call_raw = rd_link;
        ret_raw  = rs1_link && (!rd_link || (rs1 != rd));
      end
      OPC_SYSTEM: begin
        imm64   = {{52{in_inst[31]}}, in_inst[31:20]};
        cls_raw = 8'h80;
        wb_fmt  = (f3 != 3'd0);
      end
      default: supported = 1'b0;
    endcase

    illegal     = !supported || (is_w && (XLEN == 32));
    dec.pc      = in_pc;
    dec.inst    = in_inst;
    dec.imm     = XLEN'(imm64);
    dec.cls     = illegal ? 8'h00 : cls_raw;
    dec.wb      = wb_fmt && (rd != 5'd0) && !illegal;
    dec.w       = is_w;
    dec.call    = call_raw && !illegal;
    dec.ret     = ret_raw && !illegal;
    dec.illegal = illegal;
  end

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            in_rdy_q, in_rdy_d;
  logic            out_vld_q, out_vld_d;
  logic            push;
  logic            pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  // FIFO bookkeeping; flush discards everything including same-cycle traffic
  always_comb begin
    push      = in_vld && in_rdy_q;
    pop       = out_vld_q && out_rdy;
    mem_d     = mem_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = dec;
        wptr_d        = ptr_inc(wptr_q);
      end
      if (pop) begin
        rptr_d = ptr_inc(rptr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    in_rdy_d  = (count_d < CW'(DEPTH));
    out_vld_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      in_rdy_q  <= in_rdy_d;
      out_vld_q <= out_vld_d;
    end
  end

  entry_t head;

  // Payload reads zero whenever the queue is empty
  assign head        = out_vld_q ? mem_q[rptr_q] : '0;
  assign in_rdy      = in_rdy_q;
  assign out_vld     = out_vld_q;
  assign out_pc      = head.pc;
  assign out_inst    = head.inst;
  assign out_imm     = head.imm;
  assign out_rd      = head.inst[11:7];
  assign out_rs1     = head.inst[19:15];
  assign out_rs2     = head.inst[24:20];
  assign out_cls     = head.cls;
  assign out_wb      = head.wb;
  assign out_w       = head.w;
  assign out_call    = head.call;
  assign out_ret     = head.ret;
  assign out_illegal = head.illegal;

endmodule

// File: tb/tb_idu_queue.sv
// Bench for idu_queue: directed decode table, FIFO corner sequences, and a
// randomized run against a queue-based reference model (XLEN=64 and XLEN=32 builds).
module tb_idu_queue;

  localparam int unsigned D   = 2;
  localparam int unsigned D32 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_vld, out_rdy, in_vld32;
  logic [31:0] in_inst;
  logic [63:0] in_pc;

  logic        in_rdy, out_vld, out_wb, out_w, out_call, out_ret, out_illegal;
  logic [63:0] out_pc, out_imm;
  logic [31:0] out_inst;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [7:0]  out_cls;

  logic        in_rdy32, out_vld32, wb32, w32, call32, ret32, ill32;
  logic [31:0] pc32, imm32, inst32;
  logic [4:0]  rd32, rs1_32, rs2_32;
  logic [7:0]  cls32;

  idu_queue #(.XLEN(64), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_inst(in_inst), .in_pc(in_pc), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_pc(out_pc), .out_inst(out_inst), .out_imm(out_imm), .out_rd(out_rd),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_cls(out_cls), .out_wb(out_wb),
    .out_w(out_w), .out_call(out_call), .out_ret(out_ret), .out_illegal(out_illegal)
  );

  idu_queue #(.XLEN(32), .DEPTH(D32)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_vld(in_vld32), .in_rdy(in_rdy32),
    .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_vld(out_vld32), .out_rdy(out_rdy),
    .out_pc(pc32), .out_inst(inst32), .out_imm(imm32), .out_rd(rd32),
    .out_rs1(rs1_32), .out_rs2(rs2_32), .out_cls(cls32), .out_wb(wb32),
    .out_w(w32), .out_call(call32), .out_ret(ret32), .out_illegal(ill32)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] imm;
    logic [7:0]  cls;
    logic        wb, w, call, ret, ill;
  } ent_t;

  ent_t mq[$];

  function automatic ent_t ref_dec(input logic [31:0] i, input logic [63:0] pc);
    ent_t   e;
    byte    fmt = "X";
    int     unit = 0;
    bit     ok = 1'b1;
    longint imm = 0;
    logic [4:0] rd  = i[11:7];
    logic [4:0] rs1 = i[19:15];
    bit link_rd  = (rd == 1) || (rd == 5);
    bit link_rs1 = (rs1 == 1) || (rs1 == 5);
    e = '0;
    case (i[6:0])
      7'h13, 7'h1B: begin fmt = "I"; unit = 0; end
      7'h37, 7'h17: begin fmt = "U"; unit = 0; end
      7'h33, 7'h3B: begin fmt = "R"; unit = i[25] ? (i[14] ? 2 : 1) : 0; end
      7'h03:        begin fmt = "I"; unit = 3; end
      7'h23:        begin fmt = "S"; unit = 4; end
      7'h63:        begin fmt = "B"; unit = 5; end
      7'h6F:        begin fmt = "J"; unit = 6; end
      7'h67:        begin fmt = "I"; unit = 6; end
      7'h73:        begin fmt = "I"; unit = 7; end
      default:      ok = 1'b0;
    endcase
    case (fmt)
      "I": imm = longint'($signed(i[31:20]));
      "S": imm = longint'($signed({i[31:25], i[11:7]}));
      "B": imm = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      "J": imm = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      "U": imm = longint'($signed({i[31:12], 12'h000}));
      default: imm = 0;
    endcase
    e.pc   = pc;
    e.inst = i;
    e.imm  = imm;
    e.ill  = !ok;
    e.w    = (i[6:0] == 7'h3B) || (i[6:0] == 7'h1B);
    e.cls  = ok ? 8'(1 << unit) : 8'h00;
    e.wb   = ok && (rd != 0) && (fmt != "S") && (fmt != "B") &&
             !((i[6:0] == 7'h73) && (i[14:12] == 3'd0));
    if (ok && i[6:0] == 7'h6F) e.call = link_rd;
    else if (ok && i[6:0] == 7'h67) begin
      if (link_rd && !link_rs1) e.call = 1'b1;
      else if (!link_rd && link_rs1) e.ret = 1'b1;
      else if (link_rd && link_rs1) begin
        e.call = 1'b1;
        e.ret  = (rs1 != rd);
      end
    end
    return e;
  endfunction

  // Advance model with the inputs applied this cycle, then step the clock
  task automatic tick();
    bit rdy = (mq.size() < D);
    bit vld = (mq.size() != 0);
    if (!rst_n || flush) mq.delete();
    else begin
      if (vld && out_rdy) void'(mq.pop_front());
      if (in_vld && rdy) mq.push_back(ref_dec(in_inst, in_pc));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    ent_t e, a;
    chk({tag, ".in_rdy"}, 64'(in_rdy), 64'(mq.size() < D));
    chk({tag, ".out_vld"}, 64'(out_vld), 64'(mq.size() != 0));
    e = (mq.size() != 0) ? mq[0] : '0;
    a.pc = out_pc; a.inst = out_inst; a.imm = out_imm; a.cls = out_cls;
    a.wb = out_wb; a.w = out_w; a.call = out_call; a.ret = out_ret; a.ill = out_illegal;
    if (e.ill) begin
      e.imm = '0; e.w = 1'b0; a.imm = '0; a.w = 1'b0;
    end
    n_chk++;
    if (a === e && {out_rd, out_rs1, out_rs2} === {e.inst[11:7], e.inst[19:15], e.inst[24:20]})
      n_pass++;
    else
      $display("FAIL %s.payload: got %h regs %h expected %h", tag, a,
               {out_rd, out_rs1, out_rs2}, e);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [31:0] inst;
    logic [63:0] imm;
    logic [7:0]  cls;
    bit          wb, w, call, ret, ill;
  } vec_t;

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [12] = '{7'h03, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h33,
                             7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F, 7'h73};
    logic [31:0] r = $urandom;
    if ($urandom_range(0, 9) < 8) r[6:0] = ops[$urandom_range(0, 11)];
    if ($urandom_range(0, 2) == 0) r[11:7]  = $urandom_range(0, 1) ? 5'd1 : 5'd5;
    if ($urandom_range(0, 2) == 0) r[19:15] = $urandom_range(0, 1) ? 5'd1 : 5'd5;
    if ($urandom_range(0, 3) == 0) r[14:12] = 3'd0;
    return r;
  endfunction

  vec_t tbl[$];
  vec_t t32[$];

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_vld = 1'b0; in_vld32 = 1'b0; out_rdy = 1'b0;
    in_inst = '0; in_pc = '0;

    // inst, imm, cls, wb, w, call, ret, ill
    tbl.push_back('{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01, 1, 0, 0, 0, 0});
    tbl.push_back('{32'h008000EF, 64'h8,                   8'h40, 1, 0, 1, 0, 0});
    tbl.push_back('{32'h00008067, 64'h0,                   8'h40, 0, 0, 0, 1, 0});
    tbl.push_back('{32'h022081B3, 64'h0,                   8'h02, 1, 0, 0, 0, 0});
    tbl.push_back('{32'h0220C1BB, 64'h0,                   8'h04, 1, 1, 0, 0, 0});
    tbl.push_back('{32'h000280E7, 64'h0,                   8'h40, 1, 0, 1, 1, 0});
    tbl.push_back('{32'h000080E7, 64'h0,                   8'h40, 1, 0, 1, 0, 0});
    tbl.push_back('{32'h000082E7, 64'h0,                   8'h40, 1, 0, 1, 1, 0});
    tbl.push_back('{32'h0000006F, 64'h0,                   8'h40, 0, 0, 0, 0, 0});
    tbl.push_back('{32'hFE20AE23, 64'hFFFF_FFFF_FFFF_FFFC, 8'h10, 0, 0, 0, 0, 0});
    tbl.push_back('{32'hFE000FE3, 64'hFFFF_FFFF_FFFF_FFFE, 8'h20, 0, 0, 0, 0, 0});
    tbl.push_back('{32'h800002B7, 64'hFFFF_FFFF_8000_0000, 8'h01, 1, 0, 0, 0, 0});
    tbl.push_back('{32'h30009173, 64'h300,                 8'h80, 1, 0, 0, 0, 0});
    tbl.push_back('{32'h00000073, 64'h0,                   8'h80, 0, 0, 0, 0, 0});
    tbl.push_back('{32'h00812203, 64'h8,                   8'h08, 1, 0, 0, 0, 0});
    tbl.push_back('{32'h00000013, 64'h0,                   8'h01, 0, 0, 0, 0, 0});
    tbl.push_back('{32'h0010809B, 64'h1,                   8'h01, 1, 1, 0, 0, 0});
    tbl.push_back('{32'h00001097, 64'h1000,                8'h01, 1, 0, 0, 0, 0});
    tbl.push_back('{32'h00000000, 64'h0,                   8'h00, 0, 0, 0, 0, 1});
    tbl.push_back('{32'h00000012, 64'h0,                   8'h00, 0, 0, 0, 0, 1});
    tbl.push_back('{32'h0000007F, 64'h0,                   8'h00, 0, 0, 0, 0, 1});

    t32.push_back('{32'h0000003B, 64'h0,                   8'h00, 0, 0, 0, 0, 1});
    t32.push_back('{32'h0010809B, 64'h0,                   8'h00, 0, 0, 0, 0, 1});
    t32.push_back('{32'h00000000, 64'h0,                   8'h00, 0, 0, 0, 0, 1});
    t32.push_back('{32'hFFF00093, 64'hFFFF_FFFF,           8'h01, 1, 0, 0, 0, 0});
    t32.push_back('{32'h800002B7, 64'h8000_0000,           8'h01, 1, 0, 0, 0, 0});

    // Reset state
    tick();
    chk("rst.in_rdy", 64'(in_rdy), 64'd1);
    chk("rst.out_vld", 64'(out_vld), 64'd0);
    chk("rst.payload", {out_pc ^ out_imm, 32'(out_cls) | out_inst},
        64'd0);
    chk("rst.flags", 64'({out_wb, out_w, out_call, out_ret, out_illegal, out_rd, out_rs1, out_rs2}), 64'd0);
    chk("rst32.vld_rdy", 64'({out_vld32, in_rdy32}), 64'b01);
    rst_n = 1'b1;

    // Directed decode table: push one, check head, pop it
    for (int k = 0; k < tbl.size(); k++) begin
      string tg = $sformatf("tbl%0d", k);
      in_vld = 1'b1; in_inst = tbl[k].inst; in_pc = 64'h8000_0000 + 64'(4 * k);
      chk({tg, ".pre_vld"}, 64'(out_vld), 64'd0);
      tick();
      in_vld = 1'b0;
      chk({tg, ".vld"}, 64'(out_vld), 64'd1);
      chk({tg, ".pc"}, out_pc, 64'h8000_0000 + 64'(4 * k));
      chk({tg, ".inst"}, 64'(out_inst), 64'(tbl[k].inst));
      if (!tbl[k].ill) chk({tg, ".imm"}, out_imm, tbl[k].imm);
      if (!tbl[k].ill) chk({tg, ".w"}, 64'(out_w), 64'(tbl[k].w));
      chk({tg, ".cls"}, 64'(out_cls), 64'(tbl[k].cls));
      chk({tg, ".wb"}, 64'(out_wb), 64'(tbl[k].wb));
      chk({tg, ".call_ret"}, 64'({out_call, out_ret}), 64'({tbl[k].call, tbl[k].ret}));
      chk({tg, ".ill"}, 64'(out_illegal), 64'(tbl[k].ill));
      chk({tg, ".regs"}, 64'({out_rd, out_rs1, out_rs2}),
          64'({tbl[k].inst[11:7], tbl[k].inst[19:15], tbl[k].inst[24:20]}));
      out_rdy = 1'b1;
      tick();
      out_rdy = 1'b0;
      chk({tg, ".popped"}, 64'(out_vld), 64'd0);
    end

    // Backpressure: three back-to-back pushes into a two-entry queue
    in_vld = 1'b1; in_inst = 32'h00100093; in_pc = 64'hA0;
    tick();
    chk("bp.rdy1", 64'(in_rdy), 64'd1);
    in_inst = 32'h00200113; in_pc = 64'hA4;
    tick();
    chk("bp.rdy2", 64'(in_rdy), 64'd0);
    in_inst = 32'h00300193; in_pc = 64'hA8;
    tick();
    chk("bp.held_rdy", 64'(in_rdy), 64'd0);
    chk("bp.head0", out_pc, 64'hA0);
    out_rdy = 1'b1;
    tick();
    chk("bp.head1", out_pc, 64'hA4);
    chk("bp.rdy_after_pop", 64'(in_rdy), 64'd1);
    tick();
    chk("bp.head2", out_pc, 64'hA8);
    chk("bp.pushpop_rdy", 64'({out_vld, in_rdy}), 64'b11);
    check_model("bp");
    in_vld = 1'b0;
    tick();
    chk("bp.drained", 64'(out_vld), 64'd0);
    out_rdy = 1'b0;

    // Flush with two queued and a same-cycle push
    in_vld = 1'b1; in_inst = 32'h00100093; in_pc = 64'hB0;
    tick();
    in_pc = 64'hB4;
    tick();
    chk("fl.full", 64'({out_vld, in_rdy}), 64'b10);
    flush = 1'b1; in_pc = 64'hB8; in_inst = 32'h00500293;
    tick();
    flush = 1'b0; in_vld = 1'b0;
    chk("fl.vld_rdy", 64'({out_vld, in_rdy}), 64'b01);
    chk("fl.payload", out_pc | 64'(out_inst) | out_imm, 64'd0);
    tick();
    chk("fl.no_ghost", 64'(out_vld), 64'd0);

    // Reset with a full queue
    in_vld = 1'b1; in_inst = 32'h00100093; in_pc = 64'hC0;
    tick();
    tick();
    in_vld = 1'b0;
    chk("rf.full", 64'(in_rdy), 64'd0);
    rst_n = 1'b0; flush = 1'b1;
    tick();
    rst_n = 1'b1; flush = 1'b0;
    chk("rf.vld_rdy", 64'({out_vld, in_rdy}), 64'b01);
    check_model("rf");

    // XLEN=32 build
    for (int k = 0; k < t32.size(); k++) begin
      string tg = $sformatf("x32_%0d", k);
      in_vld32 = 1'b1; in_inst = t32[k].inst; in_pc = 64'h1234_5678_0000_0100 + 64'(4 * k);
      tick();
      in_vld32 = 1'b0;
      chk({tg, ".vld"}, 64'(out_vld32), 64'd1);
      chk({tg, ".pc"}, 64'(pc32), 64'h0000_0100 + 64'(4 * k));
      chk({tg, ".inst"}, 64'(inst32), 64'(t32[k].inst));
      if (!t32[k].ill) chk({tg, ".imm"}, 64'(imm32), t32[k].imm);
      chk({tg, ".cls_wb_ill"}, 64'({cls32, wb32, call32, ret32, ill32}),
          64'({t32[k].cls, t32[k].wb, t32[k].call, t32[k].ret, t32[k].ill}));
      out_rdy = 1'b1;
      tick();
      out_rdy = 1'b0;
      chk({tg, ".popped"}, 64'(out_vld32), 64'd0);
    end

    // Randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      in_vld  = ($urandom_range(0, 99) < 70);
      out_rdy = ($urandom_range(0, 99) < 55);
      flush   = ($urandom_range(0, 99) < 4);
      rst_n   = ($urandom_range(0, 299) != 0);
      in_inst = rand_inst();
      in_pc   = {$urandom, $urandom};
      tick();
      check_model("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
